pdp8_bus_master: RTL and testbench
==================================

PDP8_BUS_MASTER -- requirements
Module: pdp8_bus_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: request address width.
REQ-002 SHALL have parameter DATA_W, default 12: data word width.
REQ-003 SHALL have parameter NIB_W, default 4: data nibble width, which is also the bus_in width.
REQ-004 SHALL have parameter ABEAT_W, default 6: address bits per beat; bus_out width OW=ABEAT_W+2; legal only if ABEAT_W-NIB_W >= 2 and 2^(ABEAT_W-NIB_W)-1 >= DBEATS.
REQ-005 SHALL have parameter MAX_WAIT, default 15: wait-state timeout in cycles.
REQ-006 clk  in  1  clock; all flops rise-edge.
REQ-007 reset  in  1  reset, synchronous, active-high.
REQ-008 req_valid  in  1  transaction request.
REQ-009 req_ready  out  1  request accepted when req_valid and req_ready are both high.
REQ-010 req_write / req_io  in  1 each  write (else read) / IO transaction.
REQ-011 req_io_code  in  NIB_W+1  IO device code.
REQ-012 req_addr / req_wdata  in  ADDR_W / DATA_W  address / write data.
REQ-013 rsp_valid  out  1  one-cycle completion pulse.
REQ-014 rsp_rdata  out  DATA_W  read data.
REQ-015 rsp_io_ready / rsp_io_skip / rsp_err  out  1 each  IO ready, IO skip, timeout.
REQ-016 int_pending  out  1  sticky interrupt flag.
REQ-017 int_clear  in  1  clears int_pending.
REQ-018 bus_out  out  OW  pin bus.
REQ-019 bus_in  in  NIB_W  pin bus.
REQ-020 bus_wait  in  1  wait line.

Function
REQ-021 Beat counts SHALL be ABEATS=ceil(ADDR_W/ABEAT_W) and DBEATS=ceil(DATA_W/NIB_W); operands are zero-extended, and beats are sent most-significant slice first.
REQ-022 FSM SHALL have states IDLE -> ADDR (ABEATS beats) -> IO (1 beat, only if req_io) -> DATA (DBEATS beats) -> IDLE, one beat per cycle.
REQ-023 req_ready SHALL be high in IDLE and during the final DATA beat.
REQ-024 Accepted request fields SHALL be latched; the first ADDR beat is driven in the cycle after acceptance, so acceptance in the final beat gives back-to-back transactions.
REQ-025 ADDR beat bus_out SHALL be {1, last_addr_beat, addr slice}.
REQ-026 IO beat bus_out SHALL be {0, all-ones index field, io_code}; in this beat bus_in[0] is captured to rsp_io_ready and bus_in[1] to rsp_io_skip.
REQ-027 DATA beat k (k=0 most significant) bus_out SHALL be {0, k in ABEAT_W-NIB_W bits, write, nibble}, where nibble is the wdata slice for writes and 0 for reads.
REQ-028 Reads SHALL capture bus_in into nibble k in each DATA beat; rsp_rdata takes the low DATA_W bits.
REQ-029 rsp_valid SHALL pulse in the cycle after the final DATA beat, with rsp_rdata, rsp_io_ready, rsp_io_skip and rsp_err stable until the next rsp_valid.
REQ-030 rsp_io_ready and rsp_io_skip SHALL be 0 for non-IO transactions.
REQ-031 In IDLE, bus_out SHALL be 0.
REQ-032 bus_in[0] SHALL be sampled in every first ADDR beat and, if high, set int_pending.
REQ-033 int_clear SHALL clear int_pending; a simultaneous set wins.

Reset
REQ-034 Reset SHALL force: state IDLE; bus_out, rsp_* and int_pending to 0; req_ready to 1.
REQ-035 Reset mid-transaction SHALL abort it with no rsp_valid, and the next cycle is IDLE.

Configuration
REQ-036 With PDP8_BUS_WAIT_EN defined: bus_wait high in a DATA beat SHALL repeat that beat (bus_out held, bus_in not captured, req_ready low) and count; after MAX_WAIT consecutive wait cycles, DATA ends with rsp_valid, rsp_err=1 and rsp_rdata=0.
REQ-037 Without PDP8_BUS_WAIT_EN: bus_wait SHALL be ignored, rsp_err SHALL be constant 0, and no wait counter SHALL be built.

Verification (default parameters)
REQ-038 Write addr 0x29C, data 0xFAC accepted at T -> bus_out 0x8A, 0xDC, 0x1F, 0x3A, 0x5C at T+1..T+5; rsp_valid at T+6.
REQ-039 Read addr 0x080, bus_in 0x7, 0x0, 0x1 in DATA beats -> bus_out 0x82, 0xC0, 0x00, 0x20, 0x40; rsp_rdata 0x701.
REQ-040 IO read, code 0x03, bus_in=0x3 in IO beat -> IO beat bus_out 0x63; rsp_io_ready=1 and rsp_io_skip=1.
REQ-041 Second request held valid during the final beat -> its address beat follows with no idle cycle; int set by bus_in[0]=1 in the first ADDR beat together with int_clear -> int_pending=1.
REQ-042 With the macro, bus_wait held 15 cycles in DATA beat 1 -> rsp_err=1, rsp_rdata=0; reset asserted at beat 2 -> no rsp_valid, bus_out=0.

Source files
------------

// File: rtl/pdp8_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pdp8_bus_master                                                            |
// | Serialises address / IO-code / data beats onto a narrow pin bus.           |
// | Optional feature: define PDP8_BUS_WAIT_EN for data-phase wait states.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pdp8_bus_master #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 12,
    parameter int NIB_W    = 4,
    parameter int ABEAT_W  = 6,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic                req_io,
    input  logic [NIB_W:0]      req_io_code,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_io_ready,
    output logic                rsp_io_skip,
    output logic                rsp_err,
    output logic                int_pending,
    input  logic                int_clear,
    output logic [ABEAT_W+1:0]  bus_out,
    input  logic [NIB_W-1:0]    bus_in,
    input  logic                bus_wait
);

    localparam int c_abeats    = (ADDR_W + ABEAT_W - 1) / ABEAT_W;
    localparam int c_dbeats    = (DATA_W + NIB_W - 1) / NIB_W;
    localparam int c_apad_w    = c_abeats * ABEAT_W;
    localparam int c_dpad_w    = c_dbeats * NIB_W;
    localparam int c_idx_w     = ABEAT_W - NIB_W;
    localparam int c_max_beats = (c_abeats > c_dbeats) ? c_abeats : c_dbeats;
    localparam int c_cnt_w     = (c_max_beats > 1) ? $clog2(c_max_beats) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_IO, S_DATA} state_t;

    state_t                 r_state, w_state_nxt;
    logic [c_cnt_w-1:0]     r_beat, w_beat_nxt;
    logic [c_apad_w-1:0]    r_addr;
    logic [c_dpad_w-1:0]    r_wdata;
    logic [c_dpad_w-1:0]    r_rd;
    logic [c_dpad_w-1:0]    w_rd_shift;
    logic [NIB_W:0]         r_code;
    logic                   r_write, r_io, r_io_ready, r_io_skip;
    logic                   w_last_abeat, w_last_dbeat, w_accept, w_done, w_int_set;
    logic                   w_stall, w_timeout;

    assign w_last_abeat = (r_beat == c_cnt_w'(c_abeats - 1));
    assign w_last_dbeat = (r_beat == c_cnt_w'(c_dbeats - 1));
    assign w_accept     = req_valid && req_ready;
    assign w_done       = (r_state == S_DATA) && ((w_last_dbeat && !w_stall) || w_timeout);
    assign w_int_set    = (r_state == S_ADDR) && (r_beat == '0) && bus_in[0];
    assign w_rd_shift   = (r_rd << NIB_W) | c_dpad_w'(bus_in);

`ifdef PDP8_BUS_WAIT_EN
    localparam int c_wait_w = $clog2(MAX_WAIT + 1);
    logic [c_wait_w-1:0] r_wait_cnt;

    assign w_stall   = (r_state == S_DATA) && bus_wait;
    assign w_timeout = w_stall && (r_wait_cnt == c_wait_w'(MAX_WAIT - 1));

    // Counts consecutive wait cycles only; any ready cycle restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
            rsp_err    <= 1'b0;
        end else begin
            r_wait_cnt <= (w_stall && !w_timeout) ? r_wait_cnt + c_wait_w'(1) : '0;
            if (w_done) rsp_err <= w_timeout;
        end
    end
`else
    logic w_unused_wait;
    assign w_unused_wait = bus_wait;
    assign w_stall       = 1'b0;
    assign w_timeout     = 1'b0;
    assign rsp_err       = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        bus_out     = '0;
        req_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = S_ADDR;
                    w_beat_nxt  = '0;
                end
            end
            S_ADDR: begin
                bus_out = {1'b1, w_last_abeat, r_addr[c_apad_w-1 -: ABEAT_W]};
                if (w_last_abeat) begin
                    w_state_nxt = r_io ? S_IO : S_DATA;
                    w_beat_nxt  = '0;
                end else begin
                    w_beat_nxt = r_beat + c_cnt_w'(1);
                end
            end
            S_IO: begin
                bus_out     = {1'b0, {c_idx_w{1'b1}}, r_code};
                w_state_nxt = S_DATA;
                w_beat_nxt  = '0;
            end
            S_DATA: begin
                bus_out = {1'b0, c_idx_w'(r_beat), r_write,
                           {NIB_W{r_write}} & r_wdata[c_dpad_w-1 -: NIB_W]};
                if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_beat_nxt  = '0;
                end else if (!w_stall) begin
                    if (w_last_dbeat) begin
                        // Accepting here chains the next address beat with no idle gap.
                        req_ready   = 1'b1;
                        w_state_nxt = req_valid ? S_ADDR : S_IDLE;
                        w_beat_nxt  = '0;
                    end else begin
                        w_beat_nxt = r_beat + c_cnt_w'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_beat       <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rd         <= '0;
            r_code       <= '0;
            r_write      <= 1'b0;
            r_io         <= 1'b0;
            r_io_ready   <= 1'b0;
            r_io_skip    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_io_ready <= 1'b0;
            rsp_io_skip  <= 1'b0;
            int_pending  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_beat    <= w_beat_nxt;
            rsp_valid <= 1'b0;
            case (r_state)
                S_ADDR: r_addr <= r_addr << ABEAT_W;
                S_IO: begin
                    r_io_ready <= bus_in[0];
                    r_io_skip  <= bus_in[1];
                end
                S_DATA: if (!w_stall) begin
                    r_rd    <= w_rd_shift;
                    r_wdata <= r_wdata << NIB_W;
                end
                default: ;
            endcase
            if (w_done) begin
                rsp_valid    <= 1'b1;
                rsp_rdata    <= (r_write || w_timeout) ? '0 : w_rd_shift[DATA_W-1:0];
                rsp_io_ready <= r_io_ready;
                rsp_io_skip  <= r_io_skip;
            end
            // Later assignment overrides the data shift when a request lands in the last beat.
            if (w_accept) begin
                r_addr     <= c_apad_w'(req_addr);
                r_wdata    <= c_dpad_w'(req_wdata);
                r_code     <= req_io_code;
                r_write    <= req_write;
                r_io       <= req_io;
                r_io_ready <= 1'b0;
                r_io_skip  <= 1'b0;
            end
            if (w_int_set)      int_pending <= 1'b1;
            else if (int_clear) int_pending <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pdp8_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pdp8_bus_master                                                         |
// | Scoreboard bench: per-cycle expected bus and response queues.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pdp8_bus_master;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, req_write, req_io;
    logic [4:0]  req_io_code;
    logic [11:0] req_addr, req_wdata, rsp_rdata;
    logic        rsp_valid, rsp_io_ready, rsp_io_skip, rsp_err;
    logic        int_pending, int_clear, bus_wait;
    logic [7:0]  bus_out;
    logic [3:0]  bus_in;

    always #5 clk = ~clk;

    pdp8_bus_master dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_io(req_io), .req_io_code(req_io_code),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_io_ready(rsp_io_ready), .rsp_io_skip(rsp_io_skip), .rsp_err(rsp_err),
        .int_pending(int_pending), .int_clear(int_clear),
        .bus_out(bus_out), .bus_in(bus_in), .bus_wait(bus_wait)
    );

    typedef struct packed {
        logic        wr;
        logic        io;
        logic [4:0]  code;
        logic [11:0] addr;
        logic [11:0] wdata;
        logic [3:0]  a0in;
        logic        clr0;
        logic [3:0]  ioin;
        logic [2:0][3:0] din;
        logic [2:0][4:0] waits;
    } txn_t;

    typedef struct packed {
        logic [7:0] bus;
        logic       rdy;
        logic       intp;
        logic       rv;
    } cyc_t;

    typedef struct packed {
        logic        rd;
        logic [11:0] rdata;
        logic        ior;
        logic        skip;
        logic        err;
    } rsp_t;

    cyc_t exp_q[$];
    rsp_t rsp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   m_int = 1'b0;
    bit   m_rsp_due = 1'b0;
    cyc_t mon_e;
    rsp_t mon_r;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected cycle per clock, and a response on each expected pulse.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("bus_out", 32'(bus_out), 32'(mon_e.bus));
            chk("req_ready", 32'(req_ready), 32'(mon_e.rdy));
            chk("int_pending", 32'(int_pending), 32'(mon_e.intp));
            chk("rsp_valid", 32'(rsp_valid), 32'(mon_e.rv));
            if (mon_e.rv) begin
                if (rsp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rsp_queue: got empty expected entry");
                end else begin
                    mon_r = rsp_q.pop_front();
                    if (rsp_valid) begin
                        if (mon_r.rd || mon_r.err) chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_r.rdata));
                        chk("rsp_io_ready", 32'(rsp_io_ready), 32'(mon_r.ior));
                        chk("rsp_io_skip", 32'(rsp_io_skip), 32'(mon_r.skip));
                        chk("rsp_err", 32'(rsp_err), 32'(mon_r.err));
                    end
                end
            end
        end
    end

    function automatic logic [3:0] rnd4();
        return 4'($urandom);
    endfunction

    function automatic bit bw_rand();
`ifdef PDP8_BUS_WAIT_EN
        return 1'b0;
`else
        return 1'($urandom);
`endif
    endfunction

    function automatic logic [4:0] pick_wait();
`ifdef PDP8_BUS_WAIT_EN
        int r;
        r = $urandom_range(0, 19);
        if (r < 14) return 5'd0;
        if (r < 18) return 5'($urandom_range(1, 3));
        return 5'd15;
`else
        return 5'd0;
`endif
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.wr    = 1'($urandom);
        t.io    = ($urandom_range(0, 2) == 0);
        t.code  = 5'($urandom);
        t.addr  = 12'($urandom);
        t.wdata = 12'($urandom);
        t.a0in  = rnd4();
        t.clr0  = 1'($urandom);
        t.ioin  = rnd4();
        for (int k = 0; k < 3; k++) begin
            t.din[k]   = rnd4();
            t.waits[k] = pick_wait();
        end
        return t;
    endfunction

    // One clock of stimulus plus the outputs the model expects during that clock.
    task automatic step(input bit rst, input bit v, input txn_t t, input logic [3:0] bin,
                        input bit bw, input logic [7:0] ebus, input bit erdy,
                        input bit iset, input bit fclr, input bit rnext);
        cyc_t e;
        @(posedge clk); #1;
        reset     = rst;
        req_valid = v;
        if (v) begin
            req_write   = t.wr;
            req_io      = t.io;
            req_io_code = t.code;
            req_addr    = t.addr;
            req_wdata   = t.wdata;
        end
        bus_in    = bin;
        bus_wait  = bw;
        int_clear = fclr | ($urandom_range(0, 3) == 0);
        e.bus  = ebus;
        e.rdy  = erdy;
        e.intp = m_int;
        e.rv   = m_rsp_due;
        exp_q.push_back(e);
        if (rst) begin
            m_int     = 1'b0;
            m_rsp_due = 1'b0;
        end else begin
            if (iset && bin[0]) m_int = 1'b1;
            else if (int_clear) m_int = 1'b0;
            m_rsp_due = rnext;
        end
    endtask

    task automatic idle(input bit v, input txn_t t);
        step(1'b0, v, t, rnd4(), bw_rand(), 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_txn(input txn_t t, input bit have_next, input txn_t nt,
                           input int abort_k, output bit acc_next);
        logic [7:0] eb;
        rsp_t r;
        bit   rst;
        acc_next = 1'b0;
        r.rd    = !t.wr;
        r.rdata = t.wr ? 12'h000 : {t.din[0], t.din[1], t.din[2]};
        r.ior   = t.io & t.ioin[0];
        r.skip  = t.io & t.ioin[1];
        r.err   = 1'b0;
        for (int b = 0; b < 2; b++) begin
            eb = 8'h80 | (b == 1 ? 8'h40 : 8'h00) | 8'((t.addr >> (6 * (1 - b))) & 12'h03F);
            step(1'b0, 1'b0, t, (b == 0) ? t.a0in : rnd4(), bw_rand(), eb, 1'b0,
                 b == 0, (b == 0) && t.clr0, 1'b0);
        end
        if (t.io)
            step(1'b0, 1'b0, t, t.ioin, bw_rand(), 8'h60 | 8'(t.code), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            bit last;
            last = (k == 2);
            eb   = 8'(k << 5) | (t.wr ? (8'h10 | 8'((t.wdata >> (4 * (2 - k))) & 12'h00F)) : 8'h00);
            rst  = (k == abort_k);
            for (int j = 0; j < int'(t.waits[k]) && !rst; j++) begin
                step(1'b0, last && have_next, nt, rnd4(), 1'b1, eb, 1'b0, 1'b0, 1'b0, j == 14);
                if (j == 14) begin
                    r.rdata = 12'h000;
                    r.err   = 1'b1;
                    rsp_q.push_back(r);
                    return;
                end
            end
            if (rst) begin
                step(1'b1, 1'b0, nt, rnd4(), bw_rand(), eb, last, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (last) rsp_q.push_back(r);
            step(1'b0, last && have_next, nt, t.din[k], bw_rand(), eb, last, 1'b0, 1'b0, last);
        end
        acc_next = have_next;
    endtask

    initial begin
        txn_t list[$];
        txn_t t, nt;
        bit   acc, have;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
        req_io_code = '0; req_addr = '0; req_wdata = '0;
        int_clear = 1'b0; bus_wait = 1'b0; bus_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_bus_out", 32'(bus_out), 32'h0);
        chk("reset_req_ready", 32'(req_ready), 32'h1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_rdata", 32'(rsp_rdata), 32'h0);
        chk("reset_rsp_io", 32'({rsp_io_ready, rsp_io_skip}), 32'h0);
        chk("reset_rsp_err", 32'(rsp_err), 32'h0);
        chk("reset_int", 32'(int_pending), 32'h0);

        t = '0; t.wr = 1'b1; t.addr = 12'h29C; t.wdata = 12'hFAC; list.push_back(t);
        t = '0; t.addr = 12'h080; t.din[0] = 4'h7; t.din[1] = 4'h0; t.din[2] = 4'h1; list.push_back(t);
        t = '0; t.io = 1'b1; t.code = 5'h03; t.ioin = 4'h3; list.push_back(t);
        t = '0; t.wr = 1'b1; t.addr = 12'h555; t.wdata = 12'h123; t.a0in = 4'h1; t.clr0 = 1'b1;
        list.push_back(t);
        repeat (60) list.push_back(rand_txn());

        acc = 1'b0;
        for (int i = 0; i < list.size(); i++) begin
            if (!acc) begin
                repeat ((i < 4) ? 1 : $urandom_range(0, 2)) idle(1'b0, list[i]);
                idle(1'b1, list[i]);
            end
            have = (i + 1 < list.size()) && (i == 2 || (i >= 4 && 1'($urandom)));
            nt   = have ? list[i + 1] : '0;
            run_txn(list[i], have, nt, -1, acc);
        end

`ifdef PDP8_BUS_WAIT_EN
        t = rand_txn(); t.wr = 1'b0; t.io = 1'b0; t.waits = '0; t.waits[1] = 5'd15;
        idle(1'b0, t); idle(1'b1, t);
        run_txn(t, 1'b0, '0, -1, acc);
`endif
        t = rand_txn(); t.wr = 1'b0; t.waits = '0;
        idle(1'b0, t); idle(1'b1, t);
        run_txn(t, 1'b0, '0, 2, acc);
        t = rand_txn();
        idle(1'b0, t); idle(1'b1, t);
        run_txn(t, 1'b0, '0, -1, acc);
        repeat (3) idle(1'b0, t);

        for (int c = 0; c < 20 && exp_q.size() > 0; c++) @(negedge clk);
        @(negedge clk);
        chk("exp_queue_drained", 32'(exp_q.size()), 32'h0);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
